instr_fetch_seq: RTL and testbench
==================================

# instr_fetch_seq

Parametrised multi-beat instruction fetch and decode front end. It accepts instruction beats from the narrow input pin bus (one beat per `in_valid` strobe) and assembles register-format and immediate-format instructions. It presents fully decoded fields (`opcode`, `src_a`, `src_b`, `dest`, `imm`) with a one-cycle `op_valid` pulse. It sits between the chip input pins and the execute stage, replacing the single-beat combinational fetch.

## Interface
- `IN_W`, 6: input beat width; must equal `OP_W + REG_W` and be ≥ `2*REG_W`.
- `OP_W`, 3: opcode width.
- `REG_W`, 3: register index width.
- `IMM_W`, 8: immediate width; `IMM_BEATS = ceil(IMM_W/IN_W)`, which is 2 at the defaults.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in`  input  IN_W  instruction beat.
- `in_valid`  input  1  beat strobe; a beat is consumed on every rising edge with `in_valid=1`.
- `op_valid`  output  1  one-cycle pulse: a new decoded instruction is on the field outputs.
- `opcode`  output  OP_W  decoded opcode.
- `src_a`  output  REG_W  source A register.
- `src_b`  output  REG_W  source B register.
- `dest`  output  REG_W  destination register.
- `imm`  output  IMM_W  immediate value.
- `busy`  output  1  high while a multi-beat instruction is partially assembled.

## Operation
- **Beat 0** of every instruction: `opcode = in[IN_W-1:REG_W]`, `fld = in[REG_W-1:0]`.
- **Format select** by opcode:
  - Opcode all zeros (NOP): single beat. Consumed, no `op_valid`, outputs unchanged.
  - Opcode MSB = 0, nonzero (register format): 2 beats.
    - Beat 0: `fld` → `src_a`.
    - Beat 1: `in[2*REG_W-1:REG_W]` → `src_b`, `in[REG_W-1:0]` → `dest`. Bits above `2*REG_W` are ignored.
    - `imm` is driven 0.
  - Opcode MSB = 1 (immediate format): `1 + IMM_BEATS` beats.
    - Beat 0: `fld` → `dest`.
    - Beat k (k = 1..IMM_BEATS) fills `imm[(k-1)*IN_W +: IN_W]`, low chunk first. The final beat is truncated to the remaining bits; its unused upper bits are ignored.
    - `src_a` and `src_b` are driven 0.
- **FSM states**:
  - IDLE (expect beat 0): NOP stays in IDLE; register format → REG_B1; immediate format → IMM with `cnt = 0`.
  - REG_B1: on beat → IDLE and issue.
  - IMM: on beat, `cnt++`. When the beat is the IMM_BEATS-th → IDLE and issue.
  - No transition without `in_valid`. Idle gaps of any length between beats are legal.
- **Buffering**:
  - Fields assemble in shadow registers.
  - On issue, the shadow contents are copied to the output registers and `op_valid` is set for the next cycle.
  - Outputs hold their values until the next issue.
- `busy = (state != IDLE)`.
- **Reset**: state IDLE, `cnt = 0`. `op_valid`, `busy`, and every field output are 0; shadow registers are cleared. Reset mid-instruction discards the partial instruction and no `op_valid` follows.
- **Back-to-back**: beat 0 of the next instruction may arrive in the same cycle `op_valid` is high. The output fields are not disturbed until that instruction issues.

## Timing
- `op_valid` rises on the clock edge that captures the final beat, so it is visible in the cycle after the final beat's `in_valid` cycle. It stays high for exactly one cycle, even if beats continue.
- Latency from beat 0 to `op_valid`, with no gaps:
  - Register format: 2 cycles.
  - Immediate format: `IMM_BEATS + 1` cycles, which is 3 at the defaults.
- Sustained throughput: one instruction per beat count, with no bubbles.
- `busy` is registered. It is high from the edge after beat 0 of a multi-beat op through the edge that captures its final beat.
- `rst` overrides `in_valid` in the same cycle.

## Test plan
- **Reset**: hold `rst` 2 cycles with `in_valid=1`, `in=6'h3F` → all outputs 0, no `op_valid`, `busy=0`.
- **Register op**: beats `6'b010_011`, then `6'b00_101_110` → one `op_valid` pulse 1 cycle after beat 1 with `opcode=2`, `src_a=3`, `src_b=5`, `dest=6`, `imm=0`.
- **Immediate op with gaps**: beats `6'b101_100`, `6'h2A`, `6'b111110` (only [1:0]=2'b10 used), with 3 idle cycles between each → `opcode=5`, `dest=4`, `imm=8'hAA`, `src_a=src_b=0`. `busy` stays high through the gaps. `op_valid` pulses exactly once.
- **NOP and back-to-back**:
  - NOP beat `6'b000_111`: no `op_valid`, fields held.
  - Then two register ops streamed on consecutive cycles: `op_valid` on cycles 2 and 4 after the first beat. The first op's fields hold stable through cycle 3.
- **Reset mid-op**: immediate op beat 0 and beat 1, then `rst` for 1 cycle, then register op `6'b001_001`, `6'b00_010_011` → only the register op issues (`opcode=1`, `src_a=1`, `src_b=2`, `dest=3`).
- **Parameter sweep**: `IN_W=8`, `OP_W=4`, `REG_W=4`, `IMM_W=16`, immediate op with imm beats `8'h34`, `8'h12` → `imm=16'h1234`, latency 3 cycles.

Source files
------------

// File: rtl/instr_fetch_seq_if.sv
// Beat-in / decoded-instruction-out bundle for the instruction fetch sequencer.
// The master side drives beats and the slave side (the fetch unit) drives the decoded fields.
interface instr_fetch_seq_if #(
  parameter int IN_W  = 6,
  parameter int OP_W  = 3,
  parameter int REG_W = 3,
  parameter int IMM_W = 8
);
  logic [IN_W-1:0]  in;
  logic             in_valid;
  logic             op_valid;
  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] src_a;
  logic [REG_W-1:0] src_b;
  logic [REG_W-1:0] dest;
  logic [IMM_W-1:0] imm;
  logic             busy;

  modport master (
    output in, in_valid,
    input  op_valid, opcode, src_a, src_b, dest, imm, busy
  );

  modport slave (
    input  in, in_valid,
    output op_valid, opcode, src_a, src_b, dest, imm, busy
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// Multi-beat instruction fetch/decode front end: assembles register- and
// immediate-format instructions from narrow beats and issues them with a one-cycle op_valid.
module instr_fetch_seq #(
  parameter int IN_W  = 6,
  parameter int OP_W  = 3,
  parameter int REG_W = 3,
  parameter int IMM_W = 8
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_seq_if.slave bus
);
  localparam int IMM_BEATS = (IMM_W + IN_W - 1) / IN_W;
  localparam int CNT_W     = (IMM_BEATS > 1) ? $clog2(IMM_BEATS) : 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, REG_B1, IMM} state_t;

  localparam cnt_t LAST_CNT = cnt_t'(IMM_BEATS - 1);

  state_t           state;
  cnt_t             cnt;
  logic [OP_W-1:0]  sh_opcode;
  logic [REG_W-1:0] sh_fld;
  logic [IMM_W-1:0] sh_imm;
  logic [IMM_W-1:0] imm_next;

  logic             op_valid_q;
  logic [OP_W-1:0]  opcode_q;
  logic [REG_W-1:0] src_a_q;
  logic [REG_W-1:0] src_b_q;
  logic [REG_W-1:0] dest_q;
  logic [IMM_W-1:0] imm_q;
  logic             busy_q;

  logic [OP_W-1:0]  beat_op;
  logic [REG_W-1:0] beat_fld;

  assign beat_op  = bus.in[IN_W-1:REG_W];
  assign beat_fld = bus.in[REG_W-1:0];

  // Merge the current beat into chunk cnt of the immediate; bits past IMM_W are dropped.
  always_comb begin
    imm_next = sh_imm;
    for (int unsigned i = 0; i < IMM_W; i++) begin
      if (cnt_t'(i / IN_W) == cnt) imm_next[i] = bus.in[i % IN_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sh_opcode  <= '0;
      sh_fld     <= '0;
      sh_imm     <= '0;
      op_valid_q <= 1'b0;
      opcode_q   <= '0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dest_q     <= '0;
      imm_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      op_valid_q <= 1'b0;
      if (bus.in_valid) begin
        unique case (state)
          IDLE: begin
            if (beat_op != '0) begin
              sh_opcode <= beat_op;
              sh_fld    <= beat_fld;
              sh_imm    <= '0;
              cnt       <= '0;
              state     <= beat_op[OP_W-1] ? IMM : REG_B1;
              busy_q    <= 1'b1;
            end
          end
          REG_B1: begin
            op_valid_q <= 1'b1;
            opcode_q   <= sh_opcode;
            src_a_q    <= sh_fld;
            src_b_q    <= bus.in[2*REG_W-1:REG_W];
            dest_q     <= bus.in[REG_W-1:0];
            imm_q      <= '0;
            state      <= IDLE;
            busy_q     <= 1'b0;
          end
          IMM: begin
            sh_imm <= imm_next;
            if (cnt == LAST_CNT) begin
              op_valid_q <= 1'b1;
              opcode_q   <= sh_opcode;
              src_a_q    <= '0;
              src_b_q    <= '0;
              dest_q     <= sh_fld;
              imm_q      <= imm_next;
              cnt        <= '0;
              state      <= IDLE;
              busy_q     <= 1'b0;
            end else begin
              cnt <= cnt + cnt_t'(1);
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.op_valid = op_valid_q;
  assign bus.opcode   = opcode_q;
  assign bus.src_a    = src_a_q;
  assign bus.src_b    = src_b_q;
  assign bus.dest     = dest_q;
  assign bus.imm      = imm_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed table-driven bench for instr_fetch_seq at default parameters,
// plus a hand-written immediate sequence on a widened instance.
module tb_instr_fetch_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_seq_if #(.IN_W(6), .OP_W(3), .REG_W(3), .IMM_W(8)) bus ();
  instr_fetch_seq_if #(.IN_W(8), .OP_W(4), .REG_W(4), .IMM_W(16)) bus2 ();

  instr_fetch_seq #(.IN_W(6), .OP_W(3), .REG_W(3), .IMM_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  instr_fetch_seq #(.IN_W(8), .OP_W(4), .REG_W(4), .IMM_W(16)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [5:0] in;
    logic       ov;
    logic [2:0] opc;
    logic [2:0] sa;
    logic [2:0] sb;
    logic [2:0] d;
    logic [7:0] imm;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic iv, input logic [5:0] in_v,
                              input logic ov, input logic [2:0] opc, input logic [2:0] sa,
                              input logic [2:0] sb, input logic [2:0] d,
                              input logic [7:0] imm_v, input logic b);
    vec_t v;
    v.rst = r; v.iv = iv; v.in = in_v; v.ov = ov; v.opc = opc;
    v.sa = sa; v.sb = sb; v.d = d; v.imm = imm_v; v.busy = b;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk2(input int idx, input logic ov, input logic [3:0] opc,
                      input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] d,
                      input logic [15:0] imm_v, input logic b);
    chk("w_op_valid", idx, 32'(bus2.op_valid), 32'(ov));
    chk("w_opcode",   idx, 32'(bus2.opcode),   32'(opc));
    chk("w_src_a",    idx, 32'(bus2.src_a),    32'(sa));
    chk("w_src_b",    idx, 32'(bus2.src_b),    32'(sb));
    chk("w_dest",     idx, 32'(bus2.dest),     32'(d));
    chk("w_imm",      idx, 32'(bus2.imm),      32'(imm_v));
    chk("w_busy",     idx, 32'(bus2.busy),     32'(b));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus2.in_valid = 1'b0;
    bus2.in       = '0;

    // reset held with beats present
    add(1, 1, 6'h3F,        0, 0, 0, 0, 0, 8'h00, 0);
    add(1, 1, 6'h3F,        0, 0, 0, 0, 0, 8'h00, 0);
    // register op
    add(0, 1, 6'b010_011,   0, 0, 0, 0, 0, 8'h00, 1);
    add(0, 1, 6'b00_101_110, 1, 2, 3, 5, 6, 8'h00, 0);
    add(0, 0, 6'h00,        0, 2, 3, 5, 6, 8'h00, 0);
    // immediate op with 3-cycle gaps
    add(0, 1, 6'b101_100,   0, 2, 3, 5, 6, 8'h00, 1);
    add(0, 0, 6'h00,        0, 2, 3, 5, 6, 8'h00, 1);
    add(0, 0, 6'h00,        0, 2, 3, 5, 6, 8'h00, 1);
    add(0, 0, 6'h00,        0, 2, 3, 5, 6, 8'h00, 1);
    add(0, 1, 6'h2A,        0, 2, 3, 5, 6, 8'h00, 1);
    add(0, 0, 6'h00,        0, 2, 3, 5, 6, 8'h00, 1);
    add(0, 0, 6'h00,        0, 2, 3, 5, 6, 8'h00, 1);
    add(0, 0, 6'h00,        0, 2, 3, 5, 6, 8'h00, 1);
    add(0, 1, 6'b111110,    1, 5, 0, 0, 4, 8'hAA, 0);
    add(0, 0, 6'h00,        0, 5, 0, 0, 4, 8'hAA, 0);
    // NOP, then two register ops back-to-back
    add(0, 1, 6'b000_111,   0, 5, 0, 0, 4, 8'hAA, 0);
    add(0, 1, 6'b011_001,   0, 5, 0, 0, 4, 8'hAA, 1);
    add(0, 1, 6'b00_010_100, 1, 3, 1, 2, 4, 8'h00, 0);
    add(0, 1, 6'b001_111,   0, 3, 1, 2, 4, 8'h00, 1);
    add(0, 1, 6'b110_101,   1, 1, 7, 6, 5, 8'h00, 0);
    add(0, 0, 6'h00,        0, 1, 7, 6, 5, 8'h00, 0);
    // reset in the middle of an immediate op
    add(0, 1, 6'b110_010,   0, 1, 7, 6, 5, 8'h00, 1);
    add(0, 1, 6'h15,        0, 1, 7, 6, 5, 8'h00, 1);
    add(1, 1, 6'h3F,        0, 0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 6'b001_001,   0, 0, 0, 0, 0, 8'h00, 1);
    add(0, 1, 6'b00_010_011, 1, 1, 1, 2, 3, 8'h00, 0);
    add(0, 1, 6'b000_000,   0, 1, 1, 2, 3, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst          = vecs[i].rst;
      bus.in_valid = vecs[i].iv;
      bus.in       = vecs[i].in;
      @(posedge clk);
      #1;
      chk("op_valid", i, 32'(bus.op_valid), 32'(vecs[i].ov));
      chk("opcode",   i, 32'(bus.opcode),   32'(vecs[i].opc));
      chk("src_a",    i, 32'(bus.src_a),    32'(vecs[i].sa));
      chk("src_b",    i, 32'(bus.src_b),    32'(vecs[i].sb));
      chk("dest",     i, 32'(bus.dest),     32'(vecs[i].d));
      chk("imm",      i, 32'(bus.imm),      32'(vecs[i].imm));
      chk("busy",     i, 32'(bus.busy),     32'(vecs[i].busy));
    end

    @(negedge clk);
    bus.in_valid = 1'b0;
    chk2(100, 0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 0);

    // widened instance: opcode 9 (immediate), dest A, imm 0x1234 low chunk first
    bus2.in_valid = 1'b1;
    bus2.in       = 8'h9A;
    @(posedge clk); #1;
    chk2(101, 0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 1);
    @(negedge clk);
    bus2.in = 8'h34;
    @(posedge clk); #1;
    chk2(102, 0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 1);
    @(negedge clk);
    bus2.in = 8'h12;
    @(posedge clk); #1;
    chk2(103, 1, 4'h9, 4'h0, 4'h0, 4'hA, 16'h1234, 0);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    bus2.in       = 8'hFF;
    @(posedge clk); #1;
    chk2(104, 0, 4'h9, 4'h0, 4'h0, 4'hA, 16'h1234, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
